bus_rx: RTL and testbench

BUS_RX -- requirements
Module: bus_rx

---
 rtl/bus_rx.sv | 99 +++++++++
 tb/tb_bus_rx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rx.sv
// Receive side of a 4-phase strobe/ack bus handshake, feeding a first-word
// fall-through buffer that a consumer drains with rd_en.
module bus_rx #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         bus_data,
    input  logic                     bus_strobe,
    output logic                     bus_ack,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [0:0] {StIdle, StAck} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push, pop;

    // A word is taken only on the IDLE->ACK transition; holding strobe in ACK writes nothing.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus_strobe && !full) begin
                    push    = 1'b1;
                    state_d = StAck;
                end
            end
            StAck: begin
                if (!bus_strobe) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pop = rd_en && !empty;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (rd_en && empty) begin
                err_q <= 1'b1;
            end
        end
    end

    // Storage is not reset; contents are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= bus_data;
        end
    end

    assign bus_ack       = (state_q == StAck);
    assign rd_data       = mem_q[rd_ptr_q];
    assign count         = count_q;
    assign empty         = (count_q == '0);
    assign full          = (count_q == CW'(DEPTH));
    assign err_underflow = err_q;

endmodule

// File: tb/tb_bus_rx.sv
// Bench for bus_rx: directed handshake/FIFO scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_bus_rx;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] bus_data;
    logic             bus_strobe;
    logic             bus_ack;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             empty;
    logic             full;
    logic [2:0]       count;
    logic             err_underflow;

    int vectors;
    int errs;

    // Reference model: buffered words, whether the driver has been acked, sticky error.
    logic [WIDTH-1:0] mq[$];
    bit               m_ack;
    bit               m_err;

    bus_rx #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_data     (bus_data),
        .bus_strobe   (bus_strobe),
        .bus_ack      (bus_ack),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and apply the edge to the reference model.
    task automatic tick();
        bit m_full, m_empty, do_push, do_pop;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_ack = 1'b0;
            m_err = 1'b0;
        end else begin
            m_full  = (mq.size() == DEPTH);
            m_empty = (mq.size() == 0);
            do_push = !m_ack && bus_strobe && !m_full;
            do_pop  = rd_en && !m_empty;
            if (rd_en && m_empty) m_err = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(bus_data);
            m_ack = m_ack ? bus_strobe : do_push;
        end
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus_strobe = 1'b0; rd_en = 1'b0; bus_data = '0;
        tick(); tick();
        rst_n = 1'b1;
        vectors++;
        if ({bus_ack, full, empty, count, err_underflow} !== {1'b0, 1'b0, 1'b1, 3'd0, 1'b0}) begin
            $display("FAIL reset_state: ack/full/empty/count/err = %b required 0010000",
                     {bus_ack, full, empty, count, err_underflow});
            errs++;
        end
    endtask

    task automatic test_single();
        bus_data = 8'hCC; bus_strobe = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus_ack !== 1'b1 || count !== 3'd1) begin
                $display("FAIL single_ack_hold cyc%0d: ack=%b count=%0d required ack=1 count=1",
                         i + 1, bus_ack, count);
                errs++;
            end
        end
        bus_strobe = 1'b0;
        tick();
        vectors++;
        if (bus_ack !== 1'b0 || rd_data !== 8'hCC) begin
            $display("FAIL single_release: ack=%b rd_data=%h required ack=0 rd_data=cc",
                     bus_ack, rd_data);
            errs++;
        end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        vectors++;
        if (empty !== 1'b1 || count !== 3'd0) begin
            $display("FAIL single_pop: empty=%b count=%0d required empty=1 count=0", empty, count);
            errs++;
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            bus_data = 8'(i); bus_strobe = 1'b1; tick();
            bus_strobe = 1'b0; tick();
        end
        vectors++;
        if (full !== 1'b1 || count !== 3'd4) begin
            $display("FAIL fill_full: full=%b count=%0d required full=1 count=4", full, count);
            errs++;
        end
        bus_data = 8'h05; bus_strobe = 1'b1;
        tick(); tick();
        vectors++;
        if (bus_ack !== 1'b0 || count !== 3'd4) begin
            $display("FAIL fill_backpressure: ack=%b count=%0d required ack=0 count=4",
                     bus_ack, count);
            errs++;
        end
        vectors++;
        if (rd_data !== 8'h01) begin
            $display("FAIL fill_head: rd_data=%h required 01", rd_data);
            errs++;
        end
        // Pop while full: the held push must still be blocked on this edge.
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        vectors++;
        if (bus_ack !== 1'b0 || count !== 3'd3) begin
            $display("FAIL fill_pop_while_full: ack=%b count=%0d required ack=0 count=3",
                     bus_ack, count);
            errs++;
        end
        tick();
        vectors++;
        if (bus_ack !== 1'b1 || count !== 3'd4) begin
            $display("FAIL fill_late_capture: ack=%b count=%0d required ack=1 count=4",
                     bus_ack, count);
            errs++;
        end
        bus_strobe = 1'b0; tick();
        for (int i = 2; i <= 5; i++) begin
            vectors++;
            if (rd_data !== 8'(i)) begin
                $display("FAIL fill_drain: rd_data=%h required %h", rd_data, 8'(i));
                errs++;
            end
            rd_en = 1'b1; tick(); rd_en = 1'b0;
        end
        vectors++;
        if (empty !== 1'b1) begin
            $display("FAIL fill_empty: empty=%b required 1", empty);
            errs++;
        end
    endtask

    task automatic test_simultaneous();
        bus_data = 8'hAA; bus_strobe = 1'b1; tick(); bus_strobe = 1'b0; tick();
        bus_data = 8'hBB; bus_strobe = 1'b1; tick(); bus_strobe = 1'b0; tick();
        bus_data = 8'hCC; bus_strobe = 1'b1; rd_en = 1'b1;
        tick();
        rd_en = 1'b0; bus_strobe = 1'b0;
        vectors++;
        if (count !== 3'd2 || rd_data !== 8'hBB) begin
            $display("FAIL simul_pushpop: count=%0d rd_data=%h required count=2 rd_data=bb",
                     count, rd_data);
            errs++;
        end
        tick();
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        vectors++;
        if (rd_data !== 8'hCC || count !== 3'd1) begin
            $display("FAIL simul_order: rd_data=%h count=%0d required rd_data=cc count=1",
                     rd_data, count);
            errs++;
        end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
    endtask

    task automatic test_wrap();
        int held;
        int popped;
        held = 0; popped = 0;
        for (int i = 0; i < 10; i++) begin
            bus_data = 8'(8'h10 + i); bus_strobe = 1'b1; tick(); held++;
            bus_strobe = 1'b0;
            if (held == 3) begin
                vectors++;
                if (rd_data !== 8'(8'h10 + popped)) begin
                    $display("FAIL wrap_order: rd_data=%h required %h",
                             rd_data, 8'(8'h10 + popped));
                    errs++;
                end
                rd_en = 1'b1; popped++; held--;
            end
            tick(); rd_en = 1'b0;
        end
        while (popped < 10) begin
            vectors++;
            if (rd_data !== 8'(8'h10 + popped)) begin
                $display("FAIL wrap_drain: rd_data=%h required %h", rd_data, 8'(8'h10 + popped));
                errs++;
            end
            rd_en = 1'b1; tick(); rd_en = 1'b0; popped++;
        end
    endtask

    task automatic test_underflow();
        rd_en = 1'b1; tick(); rd_en = 1'b0; tick();
        vectors++;
        if (err_underflow !== 1'b1 || count !== 3'd0 || empty !== 1'b1) begin
            $display("FAIL underflow_flag: err=%b count=%0d empty=%b required err=1 count=0 empty=1",
                     err_underflow, count, empty);
            errs++;
        end
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        vectors++;
        if (err_underflow !== 1'b0) begin
            $display("FAIL underflow_clear: err=%b required 0", err_underflow);
            errs++;
        end
    endtask

    task automatic test_reset_in_ack();
        bus_data = 8'hA1; bus_strobe = 1'b1; tick(); bus_strobe = 1'b0; tick();
        bus_data = 8'hA2; bus_strobe = 1'b1; tick();
        vectors++;
        if (bus_ack !== 1'b1 || count !== 3'd2) begin
            $display("FAIL rstack_setup: ack=%b count=%0d required ack=1 count=2", bus_ack, count);
            errs++;
        end
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        vectors++;
        if (bus_ack !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
            $display("FAIL rstack_reset: ack=%b count=%0d empty=%b required ack=0 count=0 empty=1",
                     bus_ack, count, empty);
            errs++;
        end
        tick();
        vectors++;
        if (bus_ack !== 1'b1 || count !== 3'd1 || rd_data !== 8'hA2) begin
            $display("FAIL rstack_recapture: ack=%b count=%0d rd_data=%h required 1/1/a2",
                     bus_ack, count, rd_data);
            errs++;
        end
        bus_strobe = 1'b0; tick();
        rd_en = 1'b1; tick(); rd_en = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            vectors++;
            if ({bus_ack, full, empty, count, err_underflow} !==
                {m_ack, (mq.size() == DEPTH), (mq.size() == 0), 3'(mq.size()), m_err}) begin
                $display("FAIL random_state cyc%0d: ack/full/empty/count/err=%b required %b", i,
                         {bus_ack, full, empty, count, err_underflow},
                         {m_ack, (mq.size() == DEPTH), (mq.size() == 0), 3'(mq.size()), m_err});
                errs++;
            end
            if (mq.size() != 0) begin
                vectors++;
                if (rd_data !== mq[0]) begin
                    $display("FAIL random_data cyc%0d: rd_data=%h required %h", i, rd_data, mq[0]);
                    errs++;
                end
            end
            rst_n      = ($urandom_range(0, 63) != 0);
            bus_data   = 8'($urandom);
            bus_strobe = ($urandom_range(0, 2) != 0) ? bus_strobe : ~bus_strobe;
            rd_en      = ($urandom_range(0, 3) == 0);
            tick();
        end
        rst_n = 1'b1; bus_strobe = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        m_ack   = 1'b0;
        m_err   = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_simultaneous();
        test_wrap();
        test_underflow();
        test_reset_in_ack();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
